alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq -- registered ALU with an iterative shift-add multiplier.
//
// Executes one operation per accepted request. Logic/arithmetic ops finish at
// the edge that samples start. MUL iterates for WIDTH cycles with busy high.
// out and Z are held in registers until the next completion.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   start  request strobe, sampled only when busy=0
//   ALUop  operation select (sampled with start)
//   Ain    operand A (sampled with start)
//   Bin    operand B (sampled with start); LSL uses Bin[SHW-1:0]
//   busy   high while a multiply is iterating
//   done   one-cycle pulse when out/Z update
//   out    registered result
//   Z      registered flags: [0] zero, [1] negative, [2] overflow
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       Z
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LSL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [2*WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [WIDTH-1:0]   out_n;
  logic [2:0]         z_n;
  logic               done_n;

  op_e                op;
  logic [WIDTH-1:0]   res;
  logic               ovf;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] shl_full;
  logic [2*WIDTH-1:0] acc_step;

  assign op   = op_e'(ALUop);
  assign busy = (state == MUL);

  // Single-cycle result and overflow for the non-multiply ops.
  always_comb begin
    res      = '0;
    ovf      = 1'b0;
    sum      = Ain + Bin;
    diff     = Ain - Bin;
    shl_full = {{WIDTH{1'b0}}, Ain} << Bin[SHW-1:0];
    case (op)
      OP_ADD: begin
        res = sum;
        ovf = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        // Overflow of A + ~B + 1: signs of A and B differ and result sign flips.
        res = diff;
        ovf = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (diff[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND: res = Ain & Bin;
      OP_NOT: res = ~Bin;
      OP_OR:  res = Ain | Bin;
      OP_XOR: res = Ain ^ Bin;
      OP_LSL: begin
        res = shl_full[WIDTH-1:0];
        ovf = |shl_full[2*WIDTH-1:WIDTH];
      end
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    out_n    = out;
    z_n      = Z;
    done_n   = 1'b0;
    acc_step = mplier[0] ? (acc + mcand) : acc;

    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_n  = {{WIDTH{1'b0}}, Ain};
            mplier_n = Bin;
            acc_n    = '0;
            cnt_n    = CW'(WIDTH);
            state_n  = MUL;
          end else begin
            out_n  = res;
            z_n    = {ovf, res[WIDTH-1], (res == '0)};
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n    = acc_step;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt - CW'(1);
        // Final iteration: publish the accumulator including this step's add.
        if (cnt == CW'(1)) begin
          out_n   = acc_step[WIDTH-1:0];
          z_n     = {(|acc_step[2*WIDTH-1:WIDTH]), acc_step[WIDTH-1],
                     (acc_step[WIDTH-1:0] == '0)};
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      out    <= '0;
      Z      <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      out    <= out_n;
      Z      <= z_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed, self-checking bench for alu_seq (WIDTH=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUop;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [2:0]  Z;

  int unsigned n_chk;
  int unsigned n_fail;

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ALUop (ALUop),
    .Ain   (Ain),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then drop start.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    ALUop = op;
    Ain   = a;
    Bin   = b;
    step();
    start = 1'b0;
  endtask

  // Run a multiply to completion and check timing and result.
  // With disturb set, a spurious ADD start and changing operands hit the DUT mid-iteration.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_out, input logic [2:0] exp_z,
                         input bit disturb);
    int unsigned cyc;
    int unsigned busy_cyc;
    int unsigned overlap;
    bit          got;
    issue(3'b111, a, b);
    cyc      = 0;
    busy_cyc = 0;
    overlap  = 0;
    got      = 1'b0;
    while (!got && cyc < 40) begin
      cyc++;
      if (busy) busy_cyc++;
      if (busy && done) overlap++;
      if (done) got = 1'b1;
      else begin
        if (disturb) begin
          start = (cyc == 3 || cyc == 9);
          ALUop = 3'b000;
          Ain   = 16'($urandom);
          Bin   = 16'($urandom);
        end
        step();
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, 17);
    chk({tag, "_busy_cycles"}, busy_cyc, 16);
    chk({tag, "_busy_done_overlap"}, overlap, 0);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_Z"}, Z, exp_z);
    step();
    chk({tag, "_done_single"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_out_hold"}, out, exp_out);
  endtask

  initial begin
    int unsigned extra_done;
    n_chk  = 0;
    n_fail = 0;

    // Reset with start asserted: nothing may execute.
    reset = 1'b1;
    start = 1'b1;
    ALUop = 3'b000;
    Ain   = 16'h1234;
    Bin   = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out", out, 16'h0000);
      chk("rst_Z", Z, 3'b000);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("idle_done", done, 0);

    // ADD with signed overflow into negative.
    issue(3'b000, 16'h7FFF, 16'h0001);
    chk("add_done", done, 1);
    chk("add_out", out, 16'h8000);
    chk("add_Z", Z, 3'b110);

    // SUB to zero.
    issue(3'b001, 16'd5, 16'd5);
    chk("sub_out", out, 16'h0000);
    chk("sub_Z", Z, 3'b001);

    // SUB signed overflow: 0x8000 - 1 = 0x7FFF.
    issue(3'b001, 16'h8000, 16'h0001);
    chk("subov_out", out, 16'h7FFF);
    chk("subov_Z", Z, 3'b100);

    // Back-to-back AND, XOR, NOT.
    issue(3'b010, 16'hF0F0, 16'h0FF0);
    chk("and_done", done, 1);
    chk("and_out", out, 16'h00F0);
    chk("and_Z", Z, 3'b000);
    issue(3'b101, 16'hF0F0, 16'h0FF0);
    chk("xor_done", done, 1);
    chk("xor_out", out, 16'hFF00);
    chk("xor_Z", Z, 3'b010);
    issue(3'b011, 16'h1234, 16'h0000);
    chk("not_done", done, 1);
    chk("not_out", out, 16'hFFFF);
    chk("not_Z", Z, 3'b010);
    issue(3'b100, 16'h0F00, 16'h00F0);
    chk("or_out", out, 16'h0FF0);
    chk("or_Z", Z, 3'b000);
    step();
    chk("hold_done", done, 0);
    chk("hold_out", out, 16'h0FF0);

    // Multiplies.
    run_mul("mul1", 16'd300, 16'd200, 16'hEA60, 3'b010, 1'b0);
    run_mul("mul2", 16'h0100, 16'h0100, 16'h0000, 3'b101, 1'b0);
    run_mul("mul_dist", 16'd300, 16'd200, 16'hEA60, 3'b010, 1'b1);

    // LSL: amount from Bin[3:0] only, MSB shifted out.
    issue(3'b110, 16'h8001, 16'h0011);
    chk("lsl_out", out, 16'h0002);
    chk("lsl_Z", Z, 3'b100);
    issue(3'b110, 16'h0003, 16'h000F);
    chk("lsl15_out", out, 16'h8000);
    chk("lsl15_Z", Z, 3'b110);

    // Reset in the middle of a multiply.
    issue(3'b111, 16'd300, 16'd200);
    for (int i = 1; i < 8; i++) step();
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_out", out, 16'h0000);
    chk("abort_Z", Z, 3'b000);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);
    chk("abort_out_hold", out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
